// File: rtl/us_pkg.sv
// us_pkg: shared state encoding, default timing constants and the
// median-of-3 helper used by the ultrasonic ranging sequencer.
package us_pkg;

    // FSM state encoding (kept as plain constants for legacy tools).
    typedef logic [2:0] us_state_t;
    localparam us_state_t ST_IDLE      = 3'd0;
    localparam us_state_t ST_TRIG      = 3'd1;
    localparam us_state_t ST_WAIT_RISE = 3'd2;
    localparam us_state_t ST_MEASURE   = 3'd3;
    localparam us_state_t ST_DONE      = 3'd4;

    // Defaults for a 50 MHz clock and an HC-SR04 style sensor.
    localparam int unsigned DEF_TRIG_CYCLES    = 500;
    localparam int unsigned DEF_PERIOD_CYCLES  = 3000000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1500000;
    localparam int unsigned DEF_CYCLES_PER_CM  = 2900;
    localparam int unsigned DEF_DIST_W         = 9;
    localparam int unsigned DEF_THRESH_CM      = 20;
    localparam int unsigned DEF_HYST_CM        = 2;

    // Median helper works on a fixed width; callers zero-extend distances
    // (distance widths up to 16 bits are supported).
    localparam int MED_W = 16;

    function automatic logic [MED_W-1:0] median3(
        input logic [MED_W-1:0] a,
        input logic [MED_W-1:0] b,
        input logic [MED_W-1:0] c
    );
        logic [MED_W-1:0] lo;
        logic [MED_W-1:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c <= lo)
            return lo;
        else if (c >= hi)
            return hi;
        else
            return c;
    endfunction

endpackage

// File: rtl/us_echo_sync.sv
// us_echo_sync: brings the asynchronous echo pin into the clk domain with a
// 2-FF synchroniser, then produces registered single-cycle rise/fall pulses.
// Only the second synchroniser flop feeds the edge logic, so a metastable
// first stage never fans out.
module us_echo_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_echo,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_last;
    logic r_rise;
    logic r_fall;

    // Synchronise the pin and register edge pulses from the settled level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_last <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_echo;
            r_sync <= r_meta;
            r_last <= r_sync;
            r_rise <= r_sync & ~r_last;
            r_fall <= ~r_sync & r_last;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/us_ranging_sequencer.sv
// us_ranging_sequencer: issues periodic trigger pulses to an ultrasonic
// sensor, times the echo pulse, converts its width to whole centimetres by
// counting (no divider), flags timeouts and drives a hysteretic near flag.
// Build macro US_MEDIAN3_EN: when defined, reported distance and the near
// compare use a median-of-3 over the last raw distances (adds one cycle).
//
// Interface: no handshakes. o_dist_valid and o_timeout are single-cycle
// strobes; o_distance_cm and o_near hold their value between strobes.
// o_state exposes the FSM state for debug.
module us_ranging_sequencer
    import us_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CYCLES_PER_CM  = DEF_CYCLES_PER_CM,
    parameter int unsigned DIST_W         = DEF_DIST_W,
    parameter int unsigned THRESH_CM      = DEF_THRESH_CM,
    parameter int unsigned HYST_CM        = DEF_HYST_CM
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_echo,
    input  logic              i_start_en,
    output logic              o_trig,
    output logic [DIST_W-1:0] o_distance_cm,
    output logic              o_dist_valid,
    output logic              o_timeout,
    output logic              o_near,
    output logic              o_busy,
    output logic [2:0]        o_state
);

    localparam int TR_W  = $clog2(TRIG_CYCLES + 1);
    localparam int PER_W = $clog2(PERIOD_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SUB_W = $clog2(CYCLES_PER_CM + 1);

    localparam logic [TR_W-1:0]   TRIG_LAST = TR_W'(TRIG_CYCLES - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [DIST_W-1:0] DIST_MAX  = '1;
    localparam logic [DIST_W-1:0] NEAR_ON   = DIST_W'(THRESH_CM);
    localparam logic [DIST_W-1:0] NEAR_OFF  = DIST_W'(THRESH_CM + HYST_CM);

    // A measurement window longer than the period would overlap the next trigger.
    if (TRIG_CYCLES + TIMEOUT_CYCLES >= PERIOD_CYCLES) begin : g_bad_timing
        $error("us_ranging_sequencer: TRIG_CYCLES+TIMEOUT_CYCLES must be < PERIOD_CYCLES");
    end

    us_state_t         r_state;
    logic              r_started;
    logic [PER_W-1:0]  r_period;
    logic [TR_W-1:0]   r_tcnt;
    logic [TO_W-1:0]   r_to;
    logic [SUB_W-1:0]  r_sub;
    logic [DIST_W-1:0] r_cm;
    logic              r_timeout;
    logic [DIST_W-1:0] r_dist;
    logic              r_valid;
    logic              r_near;

    logic              w_rise;
    logic              w_fall;
    logic              w_launch;
    logic              w_commit;
    logic [DIST_W-1:0] w_new;

    us_echo_sync u_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_echo (i_echo),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // First trigger after reset or re-enable fires at once; later ones wait
    // for the period grid.
    assign w_launch = (r_state == ST_IDLE) && i_start_en &&
                      (!r_started || (r_period == PER_LAST));

    // Period counter runs in every state and restarts at each trigger launch.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_period <= '0;
        else if (w_launch || (r_period == PER_LAST))
            r_period <= '0;
        else
            r_period <= r_period + 1'b1;
    end

    // Ranging FSM with trigger, timeout and echo-width counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_started <= 1'b0;
            r_tcnt    <= '0;
            r_to      <= '0;
            r_sub     <= '0;
            r_cm      <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!i_start_en) begin
                        r_started <= 1'b0;
                    end else if (w_launch) begin
                        r_state   <= ST_TRIG;
                        r_started <= 1'b1;
                        r_tcnt    <= '0;
                    end
                end
                ST_TRIG: begin
                    if (r_tcnt == TRIG_LAST) begin
                        r_state <= ST_WAIT_RISE;
                        r_to    <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                ST_WAIT_RISE: begin
                    r_to <= r_to + 1'b1;
                    if (r_to == TO_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (w_rise) begin
                        r_state <= ST_MEASURE;
                        r_sub   <= '0;
                        r_cm    <= '0;
                    end
                end
                ST_MEASURE: begin
                    r_to <= r_to + 1'b1;
                    // Every MEASURE cycle up to and including the fall edge
                    // counts, which equals the pin's high time exactly.
                    if (r_sub == SUB_LAST) begin
                        r_sub <= '0;
                        if (r_cm != DIST_MAX)
                            r_cm <= r_cm + 1'b1;
                    end else begin
                        r_sub <= r_sub + 1'b1;
                    end
                    // An echo fall on the terminal count still counts as valid.
                    if (w_fall) begin
                        r_state <= ST_DONE;
                    end else if (r_to == TO_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef US_MEDIAN3_EN
    logic [DIST_W-1:0] r_h0;
    logic [DIST_W-1:0] r_h1;
    logic [DIST_W-1:0] r_h2;
    logic [1:0]        r_hcnt;
    logic              r_pend;

    // Raw-distance history; the filtered value is published one cycle after DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h0   <= '0;
            r_h1   <= '0;
            r_h2   <= '0;
            r_hcnt <= '0;
            r_pend <= 1'b0;
        end else begin
            r_pend <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                r_h2 <= r_h1;
                r_h1 <= r_h0;
                r_h0 <= r_cm;
                if (r_hcnt != 2'd3)
                    r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    assign w_commit = r_pend;
    assign w_new    = (r_hcnt == 2'd3) ?
                      DIST_W'(median3(MED_W'(r_h0), MED_W'(r_h1), MED_W'(r_h2))) :
                      r_h0;
`else
    assign w_commit = (r_state == ST_DONE);
    assign w_new    = r_cm;
`endif

    // Publish distance, strobe valid and apply near hysteresis on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dist  <= '0;
            r_valid <= 1'b0;
            r_near  <= 1'b0;
        end else begin
            r_valid <= w_commit;
            if (w_commit) begin
                r_dist <= w_new;
                if (w_new < NEAR_ON)
                    r_near <= 1'b1;
                else if (w_new >= NEAR_OFF)
                    r_near <= 1'b0;
            end
        end
    end

    assign o_trig        = (r_state == ST_TRIG);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_state       = r_state;
    assign o_distance_cm = r_dist;
    assign o_dist_valid  = r_valid;
    assign o_timeout     = r_timeout;
    assign o_near        = r_near;

endmodule
